// File: rtl/instr_pkg.sv
// Shared defaults and helpers for the instruction queue.
// Word layout: opcode occupies the upper bits and the address field the lower bits.
package instr_pkg;

    localparam int DEFAULT_WORD_SIZE    = 10;
    localparam int DEFAULT_ADDRESS_SIZE = 8;
    localparam int OPCODE_SIZE          = DEFAULT_WORD_SIZE - DEFAULT_ADDRESS_SIZE;
    localparam int DEFAULT_DEPTH        = 4;

    // Smallest r with (1 << r) >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_queue_mem.sv
// Queue storage: one synchronous write port and one asynchronous read port.
// The array is deliberately not reset; validity is tracked by the pointers.
module instr_queue_mem #(
    parameter int WORD_SIZE = 10,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_W-1:0]     waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [PTR_W-1:0]     raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue_reg.sv
// Instruction queue between fetch and decode: circular buffer with flush.
// The head word is split into opcode/address slices and reads as zero when empty.
module instr_queue_reg
    import instr_pkg::*;
#(
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int DEPTH        = DEFAULT_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WORD_SIZE-1:0]              data_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              flush,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [WORD_SIZE-1:0]              data_out,
    output logic [ADDRESS_SIZE-1:0]           address,
    output logic [WORD_SIZE-ADDRESS_SIZE-1:0] opcode,
    output logic [clog2(DEPTH+1)-1:0]         count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic                 ready_en_reg;
    logic                 push;
    logic                 pop;
    logic [WORD_SIZE-1:0] rd_data;

    // ready_en_reg keeps in_ready low through reset and until the first edge after it.
    assign in_ready  = ready_en_reg && (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_next = count_reg - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            ready_en_reg <= 1'b1;
        end
    end

    instr_queue_mem #(
        .WORD_SIZE(WORD_SIZE),
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr_reg),
        .wdata(data_in),
        .raddr(rd_ptr_reg),
        .rdata(rd_data)
    );

    generate
        for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_out_mask
            assign data_out[gi] = out_valid & rd_data[gi];
        end
    endgenerate

    assign address = data_out[ADDRESS_SIZE-1:0];
    assign opcode  = data_out[WORD_SIZE-1:ADDRESS_SIZE];
    assign count   = count_reg;

endmodule

// File: tb/tb_instr_queue_reg.sv
// Randomized and directed checks of instr_queue_reg against a queue-based model.
module tb_instr_queue_reg;

    localparam int WORD_SIZE    = 10;
    localparam int ADDRESS_SIZE = 8;
    localparam int DEPTH        = 4;

    logic                              clk;
    logic                              rst;
    logic [WORD_SIZE-1:0]              data_in;
    logic                              in_valid;
    logic                              in_ready;
    logic                              flush;
    logic                              out_ready;
    logic                              out_valid;
    logic [WORD_SIZE-1:0]              data_out;
    logic [ADDRESS_SIZE-1:0]           address;
    logic [WORD_SIZE-ADDRESS_SIZE-1:0] opcode;
    logic [2:0]                        count;

    instr_queue_reg #(
        .WORD_SIZE   (WORD_SIZE),
        .ADDRESS_SIZE(ADDRESS_SIZE),
        .DEPTH       (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .data_out (data_out),
        .address  (address),
        .opcode   (opcode),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: queue contents and whether the queue has left reset.
    logic [WORD_SIZE-1:0] model_q[$];
    bit                   model_ready_en;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_head();
        return (model_q.size() > 0) ? int'(model_q[0]) : 0;
    endfunction

    task automatic check_outputs();
        int head;
        head = exp_head();
        check_val("out_valid", int'(out_valid), int'(model_q.size() > 0));
        check_val("data_out", int'(data_out), head);
        check_val("address", int'(address), head % (1 << ADDRESS_SIZE));
        check_val("opcode", int'(opcode), head >> ADDRESS_SIZE);
        check_val("count", int'(count), model_q.size());
        check_val("in_ready", int'(in_ready), int'(model_ready_en && model_q.size() < DEPTH));
    endtask

    // One cycle: drive inputs, check before the edge, advance the model at the edge.
    task automatic step(input bit iv, input logic [WORD_SIZE-1:0] din, input bit ordy, input bit fl);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        data_in   = din;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_outputs();
        do_push = iv && model_ready_en && (model_q.size() < DEPTH) && !fl;
        do_pop  = (model_q.size() > 0) && ordy && !fl;
        $display("cyc %0d iv=%0b din=%h ordy=%0b flush=%0b push=%0b pop=%0b count=%0d head=%h",
                 cyc, iv, din, ordy, fl, do_push, do_pop, count, data_out);
        @(posedge clk);
        cyc++;
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(din);
        end
        model_ready_en = 1'b1;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        data_in   = 10'h3FF;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_ready_en = 1'b0;

        // Reset holds everything at zero even with a word offered.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        check_val("rst_in_ready", int'(in_ready), 0);
        check_val("rst_data_out", int'(data_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 10'h3FF, 1'b0, 1'b0);
        check_val("post_rst_in_ready", int'(in_ready), 1);

        // Fill then drain in order.
        step(1'b1, 10'h101, 1'b0, 1'b0);
        step(1'b1, 10'h202, 1'b0, 1'b0);
        step(1'b1, 10'h303, 1'b0, 1'b0);
        step(1'b1, 10'h0A5, 1'b0, 1'b0);
        check_val("full_count", int'(count), 4);
        check_val("full_in_ready", int'(in_ready), 0);
        check_val("first_opcode", int'(opcode), 1);
        check_val("first_address", int'(address), 1);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        check_val("drain_2", int'(data_out), 'h202);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        check_val("drain_3", int'(data_out), 'h303);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        check_val("drain_4", int'(data_out), 'h0A5);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        check_val("drained_valid", int'(out_valid), 0);

        // Full stall: a pop while full does not admit the offered word that cycle.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 10'(16 + i), 1'b0, 1'b0);
        step(1'b1, 10'h155, 1'b1, 1'b0);
        check_val("stall_count", int'(count), 3);
        step(1'b1, 10'h155, 1'b0, 1'b0);
        check_val("stall_refill", int'(count), 4);

        // Concurrent push/pop at count 2 wraps the pointers.
        step(1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'($urandom_range(0, 1023)), 1'b1, 1'b0);
            check_val("concurrent_count", int'(count), 2);
        end

        // Flush at count 3 drops the concurrent word.
        step(1'b1, 10'h0AA, 1'b0, 1'b0);
        step(1'b1, 10'h0FF, 1'b0, 1'b1);
        check_val("flush_count", int'(count), 0);
        check_val("flush_data", int'(data_out), 0);
        check_val("flush_in_ready", int'(in_ready), 1);

        // Popping an empty queue has no effect.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'h000, 1'b1, 1'b0);
            check_val("empty_pop_count", int'(count), 0);
        end
        step(1'b1, 10'h077, 1'b1, 1'b0);
        check_val("push_latency", int'(data_out), 'h077);

        // Asynchronous reset mid-operation clears immediately.
        step(1'b1, 10'h123, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        model_ready_en = 1'b0;
        check_outputs();
        check_val("async_rst_count", int'(count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 10'($urandom_range(0, 1023)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_queue_reg.md
INSTR_QUEUE_REG -- requirements
Module: instr_queue_reg

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 10, instruction word width in bits.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 8, width of the address field (bits [ADDRESS_SIZE-1:0]); legal range 1..WORD_SIZE-1.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; legal values: power of two, 2..64.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  WORD_SIZE  instruction word from fetch.
REQ-007 SHALL have port in_valid  input  1  data_in holds a word to enqueue.
REQ-008 SHALL have port in_ready  output  1  queue can accept a word this cycle.
REQ-009 SHALL have port flush  input  1  discard all queued words (branch/jump taken).
REQ-010 SHALL have port out_ready  input  1  decode consumes the head word this cycle.
REQ-011 SHALL have port out_valid  output  1  data_out holds a valid instruction.
REQ-012 SHALL have port data_out  output  WORD_SIZE  head instruction word.
REQ-013 SHALL have port address  output  ADDRESS_SIZE  data_out[ADDRESS_SIZE-1:0].
REQ-014 SHALL have port opcode  output  WORD_SIZE-ADDRESS_SIZE  data_out[WORD_SIZE-1:ADDRESS_SIZE].
REQ-015 SHALL have port count  output  clog2(DEPTH+1)  number of valid entries.

Function
REQ-016 Push SHALL occur when in_valid && in_ready && !flush; the word is written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-017 in_ready SHALL equal (count != DEPTH), registered-state only; no combinational path from out_ready or in_valid.
REQ-018 Pop SHALL occur when out_valid && out_ready && !flush; rd_ptr increments modulo DEPTH.
REQ-019 out_valid SHALL equal (count != 0); data_out SHALL equal entry[rd_ptr] when out_valid, else all zeros.
REQ-020 Latency: a word pushed into an empty queue SHALL appear on data_out/out_valid the following cycle; no same-cycle bypass.
REQ-021 Simultaneous push and pop (count 1..DEPTH-1) SHALL leave count unchanged and advance both pointers.
REQ-022 When full, a pop SHALL NOT enable a push in the same cycle (in_ready low); push is accepted next cycle.
REQ-023 When empty, out_ready SHALL have no effect.
REQ-024 flush SHALL take priority over push and pop: next cycle count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1; a concurrent in_valid word is dropped.
REQ-025 count SHALL update as count + push - pop and never exceed DEPTH or underflow.
REQ-026 address and opcode SHALL be pure bit slices of data_out (zero when !out_valid).
REQ-027 Storage contents SHALL NOT be cleared by flush; only pointers and count reset.

Reset
REQ-028 While rst is high, count=0, rd_ptr=wr_ptr=0, out_valid=0, data_out=0, address=0, opcode=0; in_ready SHALL be 0 during reset and 1 from the first edge after deassertion.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately (asynchronous); storage array need not be reset.

Structure
REQ-030 A shared package instr_pkg SHALL hold WORD_SIZE, ADDRESS_SIZE defaults, derived OPCODE_SIZE, and the clog2 helper.
REQ-031 Storage SHALL be one sub-module instr_queue_mem (DEPTH x WORD_SIZE, one write port, one asynchronous read port, no reset).
REQ-032 Pointer/count control SHALL remain in instr_queue_reg.

Verification
REQ-033 Reset: rst=1 with in_valid=1, data_in=10'h3FF -> out_valid=0, data_out=0, count=0, in_ready=0; after release in_ready=1.
REQ-034 Fill/drain: push 10'h101,10'h202,10'h303,10'h0A5 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> data_out 101,202,303,0A5 in order, opcode 2'b01 and address 8'h01 on first.
REQ-035 Full stall: at count=4 assert in_valid with 10'h155 and out_ready=1 -> one pop, 155 not accepted that cycle, accepted next cycle, count returns to 4.
REQ-036 Concurrent push/pop: count=2, in_valid=1, out_ready=1 for 10 cycles -> count stays 2, pointers wrap past DEPTH, order preserved.
REQ-037 Flush: count=3, flush=1 with in_valid=1, data_in=10'h0FF -> next cycle count=0, out_valid=0, data_out=0; 0FF never appears.
REQ-038 Empty pop: count=0, out_ready=1 for 3 cycles -> count stays 0, no underflow; then push 10'h077 -> data_out=077 one cycle later.
